// File: rtl/bidi_bus_port_pkg.sv
// Shared types and parameter defaults for the bidirectional bus port.
package bidi_bus_port_pkg;

    typedef enum logic [1:0] {
        StRelease = 2'd0,
        StTurnOn  = 2'd1,
        StDrive   = 2'd2,
        StTurnOff = 2'd3
    } state_e;

    localparam int unsigned DefaultWidth      = 8;
    localparam int unsigned DefaultTurnCycles = 1;
    localparam int unsigned DefaultChainSeg   = 1;
    localparam int unsigned CntWidth          = 4;

endpackage

// File: rtl/bidi_chain_seg.sv
// One registered segment of the pad test chain: c[k+1] = pad[k] | ~c[k].
module bidi_chain_seg
    import bidi_bus_port_pkg::*;
#(
    parameter int unsigned SEG_W = 1
) (
    input  logic             MasterClock,
    input  logic             reset,
    input  logic [SEG_W-1:0] pad,
    input  logic             chain_in,
    output logic             chain_out
);

    logic seg_d;
    logic seg_q;

    always_comb begin
        seg_d = chain_in;
        for (int k = 0; k < int'(SEG_W); k++) begin
            seg_d = pad[k] | ~seg_d;
        end
    end

    always_ff @(posedge MasterClock) begin
        if (reset) begin
            seg_q <= 1'b1;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign chain_out = seg_q;

endmodule

// File: rtl/bidi_bus_port.sv
// Bidirectional pad port with turnaround FSM, registered loopback and a segmented test chain.
module bidi_bus_port
    import bidi_bus_port_pkg::*;
#(
    parameter int unsigned WIDTH       = DefaultWidth,
    parameter int unsigned TURN_CYCLES = DefaultTurnCycles,
    parameter int unsigned CHAIN_SEG   = DefaultChainSeg
) (
    input  logic             MasterClock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_o,
    output logic             pad_oe,
    input  logic [WIDTH-1:0] core_a,
    input  logic             en_n,
    input  logic             tn,
    output logic [WIDTH-1:0] core_o,
    output logic [WIDTH-1:0] core_zi,
    input  logic             pi,
    output logic             po,
    output logic             busy
);

    localparam logic [CntWidth-1:0] TurnLoad = CntWidth'(TURN_CYCLES);
    localparam int NumSeg = int'((WIDTH + CHAIN_SEG - 1) / CHAIN_SEG);

    state_e              state_d, state_q;
    logic [CntWidth-1:0] cnt_d, cnt_q;
    logic                req;

    assign req = ~en_n & tn;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRelease: begin
                if (req) begin
                    cnt_d   = TurnLoad;
                    state_d = (TURN_CYCLES == 0) ? StDrive : StTurnOn;
                end
            end
            StTurnOn: begin
                if (!req) begin
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    // Entering DRIVE on the edge where the count reaches zero.
                    if (cnt_q <= 1) state_d = StDrive;
                end
            end
            StDrive: begin
                if (!req) begin
                    cnt_d   = TurnLoad;
                    state_d = (TURN_CYCLES == 0) ? StRelease : StTurnOff;
                end
            end
            StTurnOff: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) state_d = StRelease;
            end
            default: state_d = StRelease;
        endcase
    end

    always_ff @(posedge MasterClock) begin
        if (reset) begin
            state_q <= StRelease;
            cnt_q   <= '0;
            pad_oe  <= 1'b0;
            pad_o   <= '0;
            core_o  <= '0;
            core_zi <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pad_oe  <= (state_d == StDrive);
            pad_o   <= core_a;
            core_o  <= (state_d == StDrive) ? core_a : pad_i;
            core_zi <= ~pad_i;
        end
    end

    assign busy = (state_q == StTurnOn) || (state_q == StTurnOff);

    logic [NumSeg:0] link;
    assign link[0] = pi;

    for (genvar s = 0; s < NumSeg; s++) begin : g_seg
        localparam int Lo = s * int'(CHAIN_SEG);
        localparam int Hi = ((s + 1) * int'(CHAIN_SEG) > int'(WIDTH)) ?
                            int'(WIDTH) : (s + 1) * int'(CHAIN_SEG);

        bidi_chain_seg #(
            .SEG_W(Hi - Lo)
        ) u_seg (
            .MasterClock(MasterClock),
            .reset      (reset),
            .pad        (pad_i[Hi-1:Lo]),
            .chain_in   (link[s]),
            .chain_out  (link[s+1])
        );
    end

    assign po = link[NumSeg];

endmodule
